dc_miss_handler: RTL

- Responder side of the dcache miss interface: consumes dc_miss/dc_evict from the dcache hit checker and returns dc_miss_ack.
- Writes back a dirty victim line, fetches the missing line over a beat-serial memory bus, then writes data, tag, valid and clean status into the dcache arrays.
- Sits between the dcache lookup stage and the memory bus arbiter.
- Uncacheable (tlb_pcd) and exception accesses never raise dc_miss, so they never reach this block.

---
 rtl/dc_miss_handler_pkg.sv | 20 ++
 rtl/dc_fill_buffer.sv | 38 +++
 rtl/dc_miss_handler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dc_miss_handler_pkg.sv
// Shared dcache miss-path definitions: geometry constants and handler state encoding.
package dc_miss_handler_pkg;

   localparam int DC_TAG_W  = 6;
   localparam int DC_IDX_W  = 5;
   localparam int DC_BUS_W  = 32;
   localparam int DC_BEATS  = 4;
   localparam int DC_OFF_W  = 4;
   localparam int DC_CNT_W  = $clog2(DC_BEATS);
   localparam int DC_LINE_W = DC_BEATS * DC_BUS_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WB   = 3'd1,
      ST_RD   = 3'd2,
      ST_FILL = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/dc_fill_buffer.sv
// Line assembly buffer: one BUS_W register per beat, beat-select write, parallel line read.
module dc_fill_buffer
   import dc_miss_handler_pkg::*;
#(
   parameter int BUS_W = DC_BUS_W,
   parameter int BEATS = DC_BEATS,
   parameter int CNT_W = DC_CNT_W
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   we,
   input  logic [CNT_W-1:0]       sel,
   input  logic [BUS_W-1:0]       wdata,
   output logic [BEATS*BUS_W-1:0] line
);

   logic [BUS_W-1:0] beat_r [BEATS];

   // Beat storage with synchronous clear
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < BEATS; i++) begin
            beat_r[i] <= '0;
         end
      end else if (we) begin
         beat_r[sel] <= wdata;
      end
   end

   // Flatten beats into the line, beat 0 in the low word
   always_comb begin
      line = '0;
      for (int i = 0; i < BEATS; i++) begin
         line[i*BUS_W +: BUS_W] = beat_r[i];
      end
   end

endmodule

// File: rtl/dc_miss_handler.sv
// Dcache miss responder: writes back a dirty victim, fetches the missing line beat by beat,
// then issues a single fill strobe to the data/tag arrays.
module dc_miss_handler
   import dc_miss_handler_pkg::*;
#(
   parameter int TAG_W = DC_TAG_W,
   parameter int IDX_W = DC_IDX_W,
   parameter int BUS_W = DC_BUS_W,
   parameter int BEATS = DC_BEATS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dc_miss,
   input  logic                     dc_evict,
   input  logic [IDX_W-1:0]         miss_idx,
   input  logic [TAG_W-1:0]         phy_tag,
   input  logic [TAG_W-1:0]         ts_tag,
   input  logic [BEATS*BUS_W-1:0]   victim_data,
   output logic                     dc_miss_ack,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [TAG_W+IDX_W+3:0]   mem_addr,
   output logic [BUS_W-1:0]         mem_wdata,
   input  logic [BUS_W-1:0]         mem_rdata,
   input  logic                     mem_ack,
   output logic                     fill_we,
   output logic [IDX_W-1:0]         fill_idx,
   output logic [TAG_W-1:0]         fill_tag,
   output logic [BEATS*BUS_W-1:0]   fill_data
);

   localparam int CNT_W = $clog2(BEATS);

   state_t                   state_r;
   state_t                   state_s;
   logic [CNT_W-1:0]         cnt_r;
   logic [IDX_W-1:0]         idx_r;
   logic [TAG_W-1:0]         tag_r;
   logic [TAG_W-1:0]         ts_tag_r;
   logic [BEATS*BUS_W-1:0]   victim_r;
   logic [BEATS*BUS_W-1:0]   line_s;
   logic                     accept_s;
   logic                     beat_done_s;
   logic                     last_s;

   assign accept_s    = (state_r == ST_IDLE) && dc_miss;
   assign beat_done_s = mem_ack && ((state_r == ST_WB) || (state_r == ST_RD));
   assign last_s      = (cnt_r == CNT_W'(BEATS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request capture at accept; beat counter advances only on a completed beat
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= '0;
         idx_r    <= '0;
         tag_r    <= '0;
         ts_tag_r <= '0;
         victim_r <= '0;
      end else if (accept_s) begin
         cnt_r    <= '0;
         idx_r    <= miss_idx;
         tag_r    <= phy_tag;
         ts_tag_r <= ts_tag;
         victim_r <= victim_data;
      end else if (beat_done_s) begin
         cnt_r    <= last_s ? '0 : cnt_r + CNT_W'(1);
      end
   end

   dc_fill_buffer #(
      .BUS_W (BUS_W),
      .BEATS (BEATS),
      .CNT_W (CNT_W)
   ) u_fill_buffer (
      .clk   (clk),
      .clr   (rst || accept_s),
      .we    (mem_ack && (state_r == ST_RD)),
      .sel   (cnt_r),
      .wdata (mem_rdata),
      .line  (line_s)
   );

   // Next state and Moore output decode; buses are zero outside the states that own them
   always_comb begin
      state_s     = state_r;
      dc_miss_ack = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_we     = 1'b0;
      fill_idx    = '0;
      fill_tag    = '0;
      fill_data   = '0;
      case (state_r)
         ST_IDLE: begin
            if (dc_miss) begin
               state_s = dc_evict ? ST_WB : ST_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WB: begin
            dc_miss_ack = 1'b1;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = {ts_tag_r, idx_r, cnt_r, 2'b00};
            mem_wdata   = victim_r[cnt_r*BUS_W +: BUS_W];
            if (mem_ack && last_s) begin
               state_s = ST_RD;
            end else begin
               state_s = ST_WB;
            end
         end
         ST_RD: begin
            dc_miss_ack = 1'b1;
            mem_req     = 1'b1;
            mem_addr    = {tag_r, idx_r, cnt_r, 2'b00};
            if (mem_ack && last_s) begin
               state_s = ST_FILL;
            end else begin
               state_s = ST_RD;
            end
         end
         ST_FILL: begin
            dc_miss_ack = 1'b1;
            fill_we     = 1'b1;
            fill_idx    = idx_r;
            fill_tag    = tag_r;
            fill_data   = line_s;
            state_s     = ST_DONE;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

endmodule
